gate_truth_sweeper: RTL

- Parametrised, self-checking truth-table sweeper for N-input logic gates.
- Drives every input combination to a gate under test and holds each vector for a programmable dwell time.
- Samples the gate output once per vector, compares it against a built-in reference for the selected gate type, and reports error count, first failing vector and pass/fail.
- Sits beside a gate instance on the lab board/bench, replacing hand-written fixed-delay stimulus sequences.

---
 rtl/gate_sweep_pkg.sv | 17 +
 rtl/gate_sweep_ref.sv | 24 ++
 rtl/gate_truth_sweeper.sv | 111 +++++++++++
 3 files changed

// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg: shared gate-mode codes, sweeper state encoding and mode legality check
package gate_sweep_pkg;
  localparam logic [2:0] MODE_AND  = 3'd0;
  localparam logic [2:0] MODE_OR   = 3'd1;
  localparam logic [2:0] MODE_NAND = 3'd2;
  localparam logic [2:0] MODE_NOR  = 3'd3;
  localparam logic [2:0] MODE_XOR  = 3'd4;
  localparam logic [2:0] MODE_XNOR = 3'd5;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  function automatic logic mode_is_legal(input logic [2:0] m);
    return m <= MODE_XNOR;
  endfunction
endpackage

// File: rtl/gate_sweep_ref.sv
// gate_ref_model: combinational expected output of an N-input gate for a given mode
module gate_ref_model
  import gate_sweep_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [N_IN-1:0] i_vec,
  input  logic [2:0]      i_mode,
  output logic            o_expected
);
  logic and_r, or_r, par_r;
  // reduce the vector once, then pick or invert the reduction for the mode
  always_comb begin
    and_r = &i_vec;
    or_r  = |i_vec;
    par_r = ^i_vec;
    o_expected = (i_mode == MODE_AND)  ?  and_r :
                 (i_mode == MODE_OR)   ?  or_r  :
                 (i_mode == MODE_NAND) ? ~and_r :
                 (i_mode == MODE_NOR)  ? ~or_r  :
                 (i_mode == MODE_XOR)  ?  par_r :
                 (i_mode == MODE_XNOR) ? ~par_r : 1'b0;
  end
endmodule

// File: rtl/gate_truth_sweeper.sv
// gate_truth_sweeper: sweeps all input vectors into a gate, checks each against a reference
module gate_truth_sweeper
  import gate_sweep_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int DWELL = 250
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [2:0]      i_mode,
  input  logic            i_dut_out,
  output logic [N_IN-1:0] o_stim,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_pass,
  output logic [N_IN:0]   o_err_count,
  output logic            o_fail_valid,
  output logic [N_IN-1:0] o_fail_vec,
  output logic            o_cfg_err
);
  localparam int DW = (DWELL > 2) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] LAST_DWELL = DW'(DWELL - 1);
  state_t          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [2:0]      mode_q, mode_d;
  logic [N_IN:0]   err_q, err_d;
  logic            fv_q, fv_d;
  logic [N_IN-1:0] fvec_q, fvec_d;
  logic            cfg_q, cfg_d;
  logic            expected;
  logic            mismatch;
  gate_ref_model #(.N_IN(N_IN)) u_ref (
    .i_vec      (vec_q),
    .i_mode     (mode_q),
    .o_expected (expected)
  );
  assign mismatch     = i_dut_out != expected;
  assign o_stim       = vec_q;
  assign o_busy       = state_q == ST_RUN;
  assign o_done       = state_q == ST_DONE;
  assign o_pass       = (state_q == ST_DONE) && (err_q == '0);
  assign o_err_count  = err_q;
  assign o_fail_valid = fv_q;
  assign o_fail_vec   = fvec_q;
  assign o_cfg_err    = cfg_q;
  // state and result registers; vec is zeroed outside RUN so it doubles as the stimulus
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      dwell_q <= '0;
      mode_q  <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fvec_q  <= '0;
      cfg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fvec_q  <= fvec_d;
      cfg_q   <= cfg_d;
    end
  end
  // start handling outside RUN; dwell/vector stepping and sampling inside RUN
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    dwell_d = dwell_q;
    mode_d  = mode_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fvec_d  = fvec_q;
    cfg_d   = 1'b0;
    if (state_q != ST_RUN) begin
      if (i_start && mode_is_legal(i_mode)) begin
        state_d = ST_RUN;
        mode_d  = i_mode;
        err_d   = '0;
        fv_d    = 1'b0;
        fvec_d  = '0;
        vec_d   = '0;
        dwell_d = '0;
      end else if (i_start) begin
        cfg_d = 1'b1;
      end
    end else if (dwell_q == LAST_DWELL) begin
      if (mismatch) begin
        err_d = err_q + (N_IN+1)'(1);
        if (!fv_q) begin
          fv_d   = 1'b1;
          fvec_d = vec_q;
        end
      end
      dwell_d = '0;
      if (vec_q == '1) begin
        state_d = ST_DONE;
        vec_d   = '0;
      end else begin
        vec_d = vec_q + N_IN'(1);
      end
    end else begin
      dwell_d = dwell_q + DW'(1);
    end
  end
endmodule
